// File: rtl/pulse_sched_pkg.sv
// Shared encodings for the pulse scheduler: channel modes and channel FSM states.
package pulse_sched_pkg;

  // Channel operating mode as carried on cfg_mode; the reserved code runs as periodic.
  typedef enum logic [1:0] {
    MODE_PERIODIC = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_BURST    = 2'd2,
    MODE_RESERVED = 2'd3
  } mode_e;

  // Channel state; completion is a registered strobe, not a state of its own.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: shadows its configuration on start, walks a period counter
// and emits registered pulse/busy/done strobes one cycle behind the counter.
module pulse_channel
  import pulse_sched_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_width,
  input  logic [1:0]         cfg_mode,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic               pulse,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  state_e             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [CNT_W-1:0]   period_reg, period_next;
  logic [CNT_W-1:0]   width_reg, width_next;
  logic [BURST_W-1:0] left_reg, left_next;
  logic               periodic_reg, periodic_next;
  logic               pulse_reg, pulse_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               fin_reg, fin_next;
  logic               err_reg, err_next;

  logic [CNT_W-1:0]   width_eff;
  logic [BURST_W-1:0] burst_eff;
  logic               periodic_cfg;
  mode_e              mode_cfg;

  // Normalise the incoming config: width in [1, P-1] (1 when P==1), pulse count >= 1.
  always_comb begin
    mode_cfg     = mode_e'(cfg_mode);
    periodic_cfg = (mode_cfg == MODE_PERIODIC) || (mode_cfg == MODE_RESERVED);
    width_eff    = cfg_width;
    if (cfg_period == CNT_W'(1) || cfg_width == '0) begin
      width_eff = CNT_W'(1);
    end else if (cfg_width >= cfg_period) begin
      width_eff = cfg_period - CNT_W'(1);
    end
    burst_eff = BURST_W'(1);
    if (mode_cfg == MODE_BURST && cfg_burst != '0) begin
      burst_eff = cfg_burst;
    end
  end

  // Next-state and output logic; stop outranks start, start outranks counting.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    period_next   = period_reg;
    width_next    = width_reg;
    left_next     = left_reg;
    periodic_next = periodic_reg;
    pulse_next    = pulse_reg;
    busy_next     = busy_reg;
    err_next      = err_reg;
    fin_next      = 1'b0;
    done_next     = fin_reg;

    // Outputs follow the counter one cycle later and freeze while en is low.
    if (en) begin
      busy_next  = (state_reg == ST_RUN);
      pulse_next = (state_reg == ST_RUN) && (count_reg < width_reg);
    end

    if (stop) begin
      state_next = ST_IDLE;
      pulse_next = 1'b0;
      busy_next  = 1'b0;
    end else if (start) begin
      if (cfg_period == '0) begin
        err_next = 1'b1;
      end else begin
        err_next      = 1'b0;
        state_next    = ST_RUN;
        count_next    = '0;
        period_next   = cfg_period;
        width_next    = width_eff;
        periodic_next = periodic_cfg;
        left_next     = burst_eff;
      end
    end else if (state_reg == ST_RUN && en) begin
      if (count_reg == period_reg - CNT_W'(1)) begin
        count_next = '0;
        if (!periodic_reg) begin
          if (left_reg == BURST_W'(1)) begin
            state_next = ST_IDLE;
            fin_next   = 1'b1;
          end else begin
            left_next = left_reg - BURST_W'(1);
          end
        end
      end else begin
        count_next = count_reg + CNT_W'(1);
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      period_reg   <= '0;
      width_reg    <= '0;
      left_reg     <= '0;
      periodic_reg <= 1'b0;
      pulse_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      fin_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      period_reg   <= period_next;
      width_reg    <= width_next;
      left_reg     <= left_next;
      periodic_reg <= periodic_next;
      pulse_reg    <= pulse_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      fin_reg      <= fin_next;
      err_reg      <= err_next;
    end
  end

  assign pulse   = pulse_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign cfg_err = err_reg;

endmodule

// File: rtl/pulse_scheduler.sv
// Multi-channel pulse scheduler: slices the packed config buses and replicates
// one independent pulse_channel per channel.
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NUM_CH*CNT_W-1:0]   cfg_period,
  input  logic [NUM_CH*CNT_W-1:0]   cfg_width,
  input  logic [NUM_CH*2-1:0]       cfg_mode,
  input  logic [NUM_CH*BURST_W-1:0] cfg_burst,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         stop,
  output logic [NUM_CH-1:0]         pulse,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH-1:0]         cfg_err
);

  genvar gi;

  // One channel per slice; channels share nothing but clock, reset and en.
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      pulse_channel #(
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
      ) u_ch (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .start      (start[gi]),
        .stop       (stop[gi]),
        .cfg_period (cfg_period[gi*CNT_W +: CNT_W]),
        .cfg_width  (cfg_width[gi*CNT_W +: CNT_W]),
        .cfg_mode   (cfg_mode[gi*2 +: 2]),
        .cfg_burst  (cfg_burst[gi*BURST_W +: BURST_W]),
        .pulse      (pulse[gi]),
        .busy       (busy[gi]),
        .done       (done[gi]),
        .cfg_err    (cfg_err[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pulse_scheduler.sv
// Bench for pulse_scheduler: hand-derived vector table, directed corner sequences
// and a randomized run, all cross-checked every cycle against an elapsed-time model.
module tb_pulse_scheduler;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 32;
  localparam int BURST_W = 16;

  logic                      clk;
  logic                      reset;
  logic                      en;
  logic [NUM_CH*CNT_W-1:0]   cfg_period;
  logic [NUM_CH*CNT_W-1:0]   cfg_width;
  logic [NUM_CH*2-1:0]       cfg_mode;
  logic [NUM_CH*BURST_W-1:0] cfg_burst;
  logic [NUM_CH-1:0]         start;
  logic [NUM_CH-1:0]         stop;
  logic [NUM_CH-1:0]         pulse;
  logic [NUM_CH-1:0]         busy;
  logic [NUM_CH-1:0]         done;
  logic [NUM_CH-1:0]         cfg_err;

  pulse_scheduler #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .BURST_W (BURST_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cfg_period (cfg_period),
    .cfg_width  (cfg_width),
    .cfg_mode   (cfg_mode),
    .cfg_burst  (cfg_burst),
    .start      (start),
    .stop       (stop),
    .pulse      (pulse),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel tracks enabled cycles elapsed since its start;
  // pulse level is (elapsed mod P) < W_eff and a finite run ends after N*P cycles.
  bit                m_run  [NUM_CH];
  bit                m_fin  [NUM_CH];
  longint            m_el   [NUM_CH];
  longint            m_p    [NUM_CH];
  longint            m_w    [NUM_CH];
  longint            m_total[NUM_CH];
  logic [NUM_CH-1:0] e_pulse, e_busy, e_done, e_err;

  task automatic model_step();
    longint p, w, n, wl;
    int     md;
    for (int c = 0; c < NUM_CH; c++) begin
      p  = longint'(cfg_period[c*CNT_W +: CNT_W]);
      w  = longint'(cfg_width[c*CNT_W +: CNT_W]);
      n  = longint'(cfg_burst[c*BURST_W +: BURST_W]);
      md = int'(cfg_mode[c*2 +: 2]);
      if (!reset) begin
        m_run[c] = 0; m_fin[c] = 0; m_el[c] = 0;
        e_pulse[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0;
      end else begin
        e_done[c] = m_fin[c];
        m_fin[c]  = 0;
        if (stop[c]) begin
          m_run[c] = 0; e_pulse[c] = 0; e_busy[c] = 0;
        end else begin
          if (en) begin
            e_busy[c]  = m_run[c];
            e_pulse[c] = m_run[c] ? ((m_el[c] % m_p[c]) < m_w[c]) : 1'b0;
          end
          if (start[c]) begin
            if (p == 0) begin
              e_err[c] = 1;
            end else begin
              wl = (w < p - 1) ? w : p - 1;
              if (wl < 1) wl = 1;
              m_p[c] = p; m_w[c] = wl; m_el[c] = 0; m_run[c] = 1; e_err[c] = 0;
              if (md == 1)      m_total[c] = p;
              else if (md == 2) m_total[c] = ((n == 0) ? 1 : n) * p;
              else              m_total[c] = 0;
            end
          end else if (m_run[c] && en) begin
            m_el[c]++;
            if (m_total[c] != 0 && m_el[c] == m_total[c]) begin
              m_run[c] = 0; m_fin[c] = 1;
            end
          end
        end
      end
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_pulse",   32'(pulse),   32'(e_pulse));
    chk("model_busy",    32'(busy),    32'(e_busy));
    chk("model_done",    32'(done),    32'(e_done));
    chk("model_cfg_err", 32'(cfg_err), 32'(e_err));
  endtask

  task automatic set_cfg(input int ch, input int p, input int w, input int m, input int n);
    cfg_period[ch*CNT_W +: CNT_W]     = CNT_W'(p);
    cfg_width[ch*CNT_W +: CNT_W]      = CNT_W'(w);
    cfg_mode[ch*2 +: 2]               = 2'(m);
    cfg_burst[ch*BURST_W +: BURST_W]  = BURST_W'(n);
  endtask

  typedef struct packed {
    logic [3:0] start;
    logic [3:0] stop;
    logic       en;
    logic [3:0] pulse;
    logic [3:0] busy;
    logic [3:0] done;
  } vec_t;

  vec_t        tbl[17];
  logic [12:1] fr_exp;

  initial begin
    reset = 1'b0; en = 1'b1; start = '0; stop = '0;
    cfg_period = '0; cfg_width = '0; cfg_mode = '0; cfg_burst = '0;

    repeat (3) tick();
    chk("reset_pulse",   32'(pulse),   32'd0);
    chk("reset_busy",    32'(busy),    32'd0);
    chk("reset_done",    32'(done),    32'd0);
    chk("reset_cfg_err", 32'(cfg_err), 32'd0);
    reset = 1'b1;

    // ch0 periodic P5 W2, ch1 burst P4 W1 N3, ch2 P3 W7 (clamped to 2), all started together.
    set_cfg(0, 5, 2, 0, 0);
    set_cfg(1, 4, 1, 2, 3);
    set_cfg(2, 3, 7, 0, 0);
    set_cfg(3, 2, 1, 0, 0);
    tbl[0]  = '{4'b0111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0000, 4'b0000, 1'b1, 4'b0111, 4'b0111, 4'b0000};
    tbl[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b0101, 4'b0111, 4'b0000};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0111, 4'b0000};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0111, 4'b0000};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b1, 4'b0110, 4'b0111, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0111, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b1, 4'b0101, 4'b0111, 4'b0000};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0111, 4'b0000};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0111, 4'b0000};
    tbl[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0111, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0101, 4'b0111, 4'b0000};
    tbl[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0111, 4'b0000};
    tbl[13] = '{4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0101, 4'b0010};
    tbl[14] = '{4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0101, 4'b0000};
    tbl[15] = '{4'b0000, 4'b0001, 1'b1, 4'b0000, 4'b0100, 4'b0000};
    tbl[16] = '{4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0100, 4'b0000};
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; en = tbl[i].en;
      tick();
      chk($sformatf("vec%0d_pulse", i), 32'(pulse), 32'(tbl[i].pulse));
      chk($sformatf("vec%0d_busy", i),  32'(busy),  32'(tbl[i].busy));
      chk($sformatf("vec%0d_done", i),  32'(done),  32'(tbl[i].done));
      $display("[TB] vec %0d start=%b stop=%b pulse=%b busy=%b done=%b",
               i, tbl[i].start, tbl[i].stop, pulse, busy, done);
    end
    start = '0; stop = '0;

    // Reset in the middle of a periodic and a burst run: everything clears, no done.
    start = 4'b0011; tick(); start = '0;
    repeat (6) tick();
    reset = 1'b0; tick();
    chk("midrst_pulse",   32'(pulse),   32'd0);
    chk("midrst_busy",    32'(busy),    32'd0);
    chk("midrst_done",    32'(done),    32'd0);
    chk("midrst_cfg_err", 32'(cfg_err), 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("midrst_no_done", 32'(done), 32'd0);
      chk("midrst_idle",    32'(busy), 32'd0);
    end
    $display("[TB] seq reset-mid-run complete");

    // P==1: effective width 1, pulse stays high continuously.
    set_cfg(2, 1, 0, 0, 0);
    start = 4'b0100; tick(); start = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("p1_high", 32'(pulse[2]), 32'd1);
    end
    $display("[TB] seq P=1 continuous complete");

    // P==0 start is rejected with sticky cfg_err; the next good start clears it.
    stop = 4'b0100; tick(); stop = '0;
    set_cfg(2, 0, 3, 0, 0);
    start = 4'b0100; tick(); start = '0;
    tick();
    chk("p0_cfg_err", 32'(cfg_err[2]), 32'd1);
    chk("p0_busy",    32'(busy[2]),    32'd0);
    set_cfg(2, 3, 1, 0, 0);
    start = 4'b0100; tick(); start = '0;
    tick();
    chk("p0_err_clear", 32'(cfg_err[2]), 32'd0);
    chk("p0_restart",   32'(busy[2]),    32'd1);
    $display("[TB] seq P=0 rejection complete");

    // stop and start together: stop wins; a later start runs with the new period.
    set_cfg(3, 2, 1, 0, 0);
    start = 4'b1000; tick(); start = '0;
    repeat (3) tick();
    set_cfg(3, 6, 3, 0, 0);
    start = 4'b1000; stop = 4'b1000; tick(); start = '0; stop = '0;
    chk("coll_busy",  32'(busy[3]),  32'd0);
    chk("coll_pulse", 32'(pulse[3]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("coll_idle",    32'(busy[3]), 32'd0);
      chk("coll_no_done", 32'(done[3]), 32'd0);
    end
    start = 4'b1000; tick(); start = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("retrig_pulse_k%0d", k), 32'(pulse[3]), 32'(((k - 1) % 6) < 3));
    end
    $display("[TB] seq stop/start collision complete");

    // en low for 3 cycles in the middle of a high phase stretches the period by 3.
    fr_exp = 12'b0011_0001_1111;
    set_cfg(0, 5, 2, 0, 0);
    en = 1'b1;
    start = 4'b0001; tick(); start = '0;
    for (int k = 1; k <= 12; k++) begin
      en = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("freeze_pulse_k%0d", k), 32'(pulse[0]), 32'(fr_exp[k]));
      chk("freeze_busy", 32'(busy[0]), 32'd1);
    end
    en = 1'b1;
    $display("[TB] seq en freeze complete");

    // Randomized traffic on all channels, checked against the model every cycle.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      en    = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 299) != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 9) == 0)
          set_cfg(c, int'($urandom_range(0, 6)), int'($urandom_range(0, 8)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        start[c] = ($urandom_range(0, 14) == 0);
        stop[c]  = ($urandom_range(0, 39) == 0);
      end
      tick();
    end
    reset = 1'b1; en = 1'b1; start = '0; stop = '0;
    $display("[TB] random phase complete");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_scheduler.md
Name: pulse_scheduler

Overview:
Multi-channel programmable pulse/tick generator; successor to the single-channel fixed-width period pulser used to pace the convolution pipeline.
Each channel independently produces periodic, one-shot or burst pulses with programmable period and high width.
Start/stop/done handshakes let the layer controller sequence line loads, MAC windows and write-back strobes from one block.
Sits between the layer controller (configuration, start/stop) and the convolution datapath (pulse consumers).

Parameters:
NUM_CH, 4, number of independent channels
CNT_W, 32, width of the period and width counters and config fields
BURST_W, 16, width of the burst-count config field

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
en  input  1  global count enable; low freezes all channel counters and outputs (hold)
cfg_period  input  NUM_CH*CNT_W  per-channel period P in cycles; channel i at [i*CNT_W +: CNT_W]
cfg_width  input  NUM_CH*CNT_W  per-channel pulse high width W in cycles
cfg_mode  input  NUM_CH*2  per-channel mode: 0 periodic, 1 one-shot, 2 burst, 3 treated as periodic
cfg_burst  input  NUM_CH*BURST_W  per-channel pulse count N for burst mode
start  input  NUM_CH  per-channel start request, single-cycle, sampled on clk
stop  input  NUM_CH  per-channel abort request, single-cycle
pulse  output  NUM_CH  registered pulse outputs
busy  output  NUM_CH  channel in RUN
done  output  NUM_CH  one-cycle completion strobe (one-shot/burst only)
cfg_err  output  NUM_CH  sticky: start rejected because P == 0; cleared by next accepted start or reset

Behaviour:
- Reset (reset==0 at clk edge): all channels IDLE; pulse, busy, done, cfg_err = 0; counters = 0. Applies mid-run; no done is emitted.
- Per-channel FSM: IDLE, RUN. done is a registered strobe, not a state.
- start in IDLE or RUN: when P==0, set cfg_err, no other change. Otherwise latch P, W, mode, N into shadow registers; count=0, pulses_left=N; enter RUN. Later config changes are ignored until the next start.
- start while RUN: restart from count=0 with newly latched config (retrigger); no done for the aborted run.
- stop: RUN->IDLE next cycle; pulse=0, busy=0, no done. stop and start in the same cycle: stop wins, start is dropped.
- Width rules: W==0 treated as 1; W>=P clamped to P-1 (at least one low cycle per period). For P==1 the effective width is 1 and pulse stays high continuously.
- In RUN, with en high, count walks 0..P-1 and wraps. pulse = (count < W_eff). All outputs are registered: start accepted at edge t gives pulse=1, busy=1 from edge t+1.
- Periodic: runs until stop or retrigger; done is never asserted.
- One-shot: equals burst with N=1.
- Burst: pulses_left decrements at each wrap (count==P-1). A wrap with pulses_left==1 -> IDLE next cycle, done=1 for exactly that cycle, busy=0 the same cycle. N==0 is treated as 1.
- en low: count, pulses_left, pulse and busy hold; start/stop are still honoured. A done strobe already due is still emitted.
- Channels are fully independent; there are no shared counters.

Decomposition:
- Package pulse_sched_pkg: mode encodings (MODE_PERIODIC=0, MODE_ONESHOT=1, MODE_BURST=2), state encodings (ST_IDLE, ST_RUN).
- Sub-module pulse_channel (one channel, CNT_W/BURST_W params), instanced NUM_CH times by generate in pulse_scheduler.
- Top level only slices the config buses and concatenates the outputs.

Test Plan:
- Reset mid-run: ch0 periodic P=5 W=2, assert reset at cycle 7 -> all outputs 0 next edge; no done.
- Periodic: ch0 P=5 W=2, start at t0 -> pulse high t0+1..t0+2, low t0+3..t0+5, repeats every 5 cycles; done never asserted.
- Burst: ch1 P=4 W=1 N=3 -> exactly 3 pulses at t0+1, +5, +9; done=1 at t0+13 only; busy falls at t0+13.
- Clamping and error: ch2 P=3 W=7 -> high 2, low 1; P=1 -> pulse constant 1; P=0 start -> cfg_err=1, busy stays 0.
- Stop/start collision: ch3 running, stop and start in the same cycle -> IDLE, pulse 0, no done; a later start retriggers with new P.
- en freeze: deassert en for 3 cycles mid-period -> pulse/count hold, then resume; period is extended by exactly 3 cycles.
